lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_lane.sv | 56 +++++
 rtl/lsu.sv | 113 +++++++++++
 tb/tb_lsu.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: width codes, FSM states, default timeout
// and the request legality rule.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } lsu_state_e;

    // Unsigned widths cannot be stored; sub-word accesses must be naturally aligned.
    function automatic logic is_illegal(input logic store, input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (funct3)
            F3_B:    bad = 1'b0;
            F3_BU:   bad = store;
            F3_H:    bad = addr_lo[0];
            F3_HU:   bad = store | addr_lo[0];
            F3_W:    bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: store byte enables and replicated write data, plus load
// extraction with sign or zero extension.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        be         = 4'b0000;
        wdata_lane = wdata;
        shifted    = rdata >> {addr_lo, 3'b000};
        load_data  = shifted;
        case (funct3)
            F3_B: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                load_data  = {{24{shifted[7]}}, shifted[7:0]};
            end
            F3_BU: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                load_data  = {24'h0, shifted[7:0]};
            end
            F3_H: begin
                be         = 4'b0011 << addr_lo;
                wdata_lane = {2{wdata[15:0]}};
                load_data  = {{16{shifted[15]}}, shifted[15:0]};
            end
            F3_HU: begin
                be         = 4'b0011 << addr_lo;
                wdata_lane = {2{wdata[15:0]}};
                load_data  = {16'h0, shifted[15:0]};
            end
            F3_W: begin
                be         = 4'b1111;
                wdata_lane = wdata;
                load_data  = shifted;
            end
            default: begin
                be         = 4'b0000;
                wdata_lane = wdata;
                load_data  = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one core request at a time, drives a single-beat memory bus
// with a bounded wait for acknowledge, and returns a one-cycle response pulse.
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state, state_next;
    logic [15:0] bus_cnt;
    logic        store_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q, wdata_q;
    logic        accept, illegal, timed_out;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, lane_load;

    assign accept    = req_valid && (state == S_IDLE);
    assign illegal   = is_illegal(req_store, req_funct3, req_addr[1:0]);
    assign timed_out = (bus_cnt == 16'(TIMEOUT - 1));

    lsu_lane u_lane (
        .funct3     (funct3_q),
        .addr_lo    (addr_q[1:0]),
        .wdata      (wdata_q),
        .rdata      (mem_rdata),
        .be         (lane_be),
        .wdata_lane (lane_wdata),
        .load_data  (lane_load)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (req_valid) state_next = illegal ? S_RESP : S_BUS;
            S_BUS:   if (mem_ack || timed_out) state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // An ack in the final counted cycle wins over the timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_cnt   <= 16'h0;
            store_q   <= 1'b0;
            funct3_q  <= 3'b000;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
        end else begin
            if (accept) begin
                store_q  <= req_store;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                bus_cnt  <= 16'h0;
                if (illegal) begin
                    rsp_err   <= 1'b1;
                    rsp_rdata <= 32'h0;
                end
            end
            if (state == S_BUS) begin
                if (mem_ack) begin
                    rsp_err   <= 1'b0;
                    rsp_rdata <= store_q ? 32'h0 : lane_load;
                end else if (timed_out) begin
                    rsp_err   <= 1'b1;
                    rsp_rdata <= 32'h0;
                end else begin
                    bus_cnt <= bus_cnt + 16'd1;
                end
            end
        end
    end

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign mem_req   = (state == S_BUS);
    assign mem_we    = mem_req & store_q;
    assign mem_be    = mem_req ? lane_be : 4'b0000;
    assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_wdata = mem_req ? lane_wdata : 32'h0;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios followed by randomized requests
// compared against a byte-lane reference model.
module tb_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        req_ready, rsp_valid, rsp_err, busy, mem_req, mem_we;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    lsu #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Reference model: access size in bytes, alignment and lane placement by arithmetic.
    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit model_illegal(input bit store, input logic [2:0] f3,
                                         input logic [31:0] addr);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        if (store && f3[2]) return 1'b1;
        return (addr % size_of(f3)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        logic [3:0] be;
        int off;
        be  = 4'b0000;
        off = int'(addr % 4);
        for (int i = 0; i < size_of(f3); i++) be[off + i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wdata);
        logic [31:0] r;
        int sz;
        sz = size_of(f3);
        r  = 32'h0;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = wdata[8*(k % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        logic [31:0] v, mask;
        int sz;
        sz   = size_of(f3);
        v    = rdata >> (8 * (addr % 4));
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        v    = v & mask;
        if (!f3[2] && v[8*sz - 1]) v = v | ~mask;
        return v;
    endfunction

    // One full transaction; ack_at is the 1-based bus cycle carrying mem_ack (outside 1..TO = never).
    task automatic applyStimulus(input string tag, input bit store, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input int ack_at);
        int          waited;
        int          req_cycles;
        bit          bad, acked;
        logic [31:0] exp_rdata;
        waited     = 0;
        req_cycles = 0;
        bad        = model_illegal(store, f3, addr);
        acked      = (ack_at >= 1 && ack_at <= TO);
        while (req_ready !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        checkOutput({tag, "/req_ready"}, req_ready, 1);
        req_valid  = 1'b1;
        req_store  = store;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        step();
        req_valid  = 1'b0;
        req_wdata  = $urandom;
        checkOutput({tag, "/busy"}, busy, 1);
        if (bad) begin
            exp_rdata = 32'h0;
            checkOutput({tag, "/ill_mem_req"}, mem_req, 0);
            checkOutput({tag, "/ill_rsp_valid"}, rsp_valid, 1);
            checkOutput({tag, "/ill_rsp_err"}, rsp_err, 1);
            checkOutput({tag, "/ill_rsp_rdata"}, rsp_rdata, exp_rdata);
        end else begin
            for (int c = 1; c <= TO + 2; c++) begin
                if (mem_req !== 1'b1) break;
                req_cycles++;
                checkOutput({tag, "/mem_addr"}, mem_addr, addr & ~32'h3);
                checkOutput({tag, "/mem_be"}, mem_be, model_be(f3, addr));
                checkOutput({tag, "/mem_we"}, mem_we, store);
                if (store) checkOutput({tag, "/mem_wdata"}, mem_wdata, model_wdata(f3, wdata));
                checkOutput({tag, "/rsp_valid_bus"}, rsp_valid, 0);
                if (c == ack_at) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                end
                step();
                mem_ack = 1'b0;
            end
            mem_ack   = 1'b0;
            exp_rdata = (acked && !store) ? model_load(f3, addr, rdata) : 32'h0;
            checkOutput({tag, "/req_cycles"}, req_cycles, acked ? ack_at : TO);
            checkOutput({tag, "/rsp_valid"}, rsp_valid, 1);
            checkOutput({tag, "/mem_req_drop"}, mem_req, 0);
            checkOutput({tag, "/rsp_err"}, rsp_err, !acked);
            checkOutput({tag, "/rsp_rdata"}, rsp_rdata, exp_rdata);
        end
        step();
        checkOutput({tag, "/rsp_valid_end"}, rsp_valid, 0);
        checkOutput({tag, "/req_ready_end"}, req_ready, 1);
        checkOutput({tag, "/rsp_rdata_hold"}, rsp_rdata, exp_rdata);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        logic [2:0]  legal_f3 [5];
        legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        $display("[TB] reset");
        rst = 1'b1;
        step();
        step();
        checkOutput("rst/mem_req", mem_req, 0);
        checkOutput("rst/mem_we", mem_we, 0);
        checkOutput("rst/mem_be", mem_be, 0);
        checkOutput("rst/mem_addr", mem_addr, 0);
        checkOutput("rst/mem_wdata", mem_wdata, 0);
        checkOutput("rst/rsp_valid", rsp_valid, 0);
        checkOutput("rst/rsp_err", rsp_err, 0);
        checkOutput("rst/rsp_rdata", rsp_rdata, 0);
        checkOutput("rst/busy", busy, 0);
        checkOutput("rst/req_ready", req_ready, 1);
        rst = 1'b0;
        step();

        $display("[TB] directed transactions");
        applyStimulus("lb_0x103", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 1);
        applyStimulus("sh_0x22", 1'b1, 3'b001, 32'h22, 32'h0000_ABCD, 32'h0, 4);
        applyStimulus("lw_0x41", 1'b0, 3'b010, 32'h41, 32'h0, 32'h0, 1);
        applyStimulus("lhu_0x42", 1'b0, 3'b101, 32'h42, 32'h0, 32'h8001_0000, 1);
        applyStimulus("timeout", 1'b0, 3'b010, 32'h80, 32'h0, 32'h1234_5678, 0);
        applyStimulus("ack_last", 1'b0, 3'b010, 32'h84, 32'h0, 32'h1234_5678, 4);
        applyStimulus("sb_bu_ill", 1'b1, 3'b100, 32'h10, 32'h55, 32'h0, 1);

        $display("[TB] reset during bus");
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h200;
        step();
        req_valid = 1'b0;
        step();
        checkOutput("rstbus/mem_req_before", mem_req, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("rstbus/mem_req", mem_req, 0);
        checkOutput("rstbus/rsp_valid", rsp_valid, 0);
        checkOutput("rstbus/req_ready", req_ready, 1);
        checkOutput("rstbus/rsp_err", rsp_err, 0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_ack = 1'b0;
        checkOutput("rstbus/stray_rsp_valid", rsp_valid, 0);
        checkOutput("rstbus/stray_busy", busy, 0);
        step();
        checkOutput("rstbus/stray_rsp_valid2", rsp_valid, 0);
        checkOutput("rstbus/rsp_rdata", rsp_rdata, 0);

        $display("[TB] back-to-back");
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h300;
        step();
        req_funct3 = 3'b100;
        req_addr   = 32'h404;
        checkOutput("b2b/mem_addr1", mem_addr, 32'h300);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1122_3344;
        step();
        mem_ack = 1'b0;
        checkOutput("b2b/rsp_valid1", rsp_valid, 1);
        checkOutput("b2b/rsp_rdata1", rsp_rdata, 32'h1122_3344);
        checkOutput("b2b/req_ready_resp", req_ready, 0);
        step();
        checkOutput("b2b/req_ready_after", req_ready, 1);
        step();
        req_valid = 1'b0;
        checkOutput("b2b/mem_req2", mem_req, 1);
        checkOutput("b2b/mem_addr2", mem_addr, 32'h404);
        checkOutput("b2b/mem_be2", mem_be, 4'b0001);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_00F0;
        step();
        mem_ack = 1'b0;
        checkOutput("b2b/rsp_valid2", rsp_valid, 1);
        checkOutput("b2b/rsp_rdata2", rsp_rdata, 32'h0000_00F0);
        step();

        $display("[TB] randomized transactions");
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = $urandom;
                step();
                mem_ack = 1'b0;
                checkOutput("idle_ack/rsp_valid", rsp_valid, 0);
                checkOutput("idle_ack/req_ready", req_ready, 1);
            end
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
            else                           f3 = legal_f3[$urandom_range(0, 4)];
            a = $urandom;
            applyStimulus("rand", 1'($urandom_range(0, 1)), f3, a, $urandom, $urandom,
                          int'($urandom_range(1, 6)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
